// File: rtl/iir_pkg.sv
// Shared types for the biquad driver: sample/coefficient widths, coefficient
// bank addressing and the driver FSM states.
package iir_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [17:0] coef_t;

  localparam int NUM_COEF = 5;

  typedef enum logic [2:0] {
    B1 = 3'd0,
    B2 = 3'd1,
    B3 = 3'd2,
    A2 = 3'd3,
    A3 = 3'd4
  } coef_addr_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } drv_state_e;

  typedef struct packed {
    coef_t b1;
    coef_t b2;
    coef_t b3;
    coef_t a2;
    coef_t a3;
  } coef_set_t;

  function automatic logic coef_hit(input logic [2:0] addr, input int idx);
    return (idx < NUM_COEF) && (addr == 3'(idx));
  endfunction

endpackage

// File: rtl/biquad_coef_bank.sv
// Double-buffered coefficient bank: host writes land in the shadow copy, a
// commit request is held until the driver is idle and then copies shadow->active.
module biquad_coef_bank
  import iir_pkg::*;
#(
  parameter coef_t RST_B1 = 18'sd1
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        coef_we,
  input  logic [2:0]  coef_addr,
  input  coef_t       coef_wdata,
  input  logic        coef_commit,
  input  logic        apply_ok,
  output logic        applied,
  output coef_set_t   active
);

  coef_t shadow_q [NUM_COEF];
  coef_t shadow_d [NUM_COEF];
  coef_t active_q [NUM_COEF];
  coef_t active_d [NUM_COEF];
  logic  pending_q, pending_d;
  logic  commit_req;

  always_comb begin
    commit_req = pending_q | coef_commit;
    applied    = apply_ok & commit_req;
    pending_d  = commit_req & ~apply_ok;
    for (int i = 0; i < NUM_COEF; i++) begin
      shadow_d[i] = (coef_we && coef_hit(coef_addr, i)) ? coef_wdata : shadow_q[i];
      // Copy from shadow_d so a write in the commit cycle is included.
      active_d[i] = applied ? shadow_d[i] : active_q[i];
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= (i == 0) ? RST_B1 : '0;
        active_q[i] <= (i == 0) ? RST_B1 : '0;
      end
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign active.b1 = active_q[0];
  assign active.b2 = active_q[1];
  assign active.b3 = active_q[2];
  assign active.a2 = active_q[3];
  assign active.a3 = active_q[4];

endmodule

// File: rtl/biquad_driver.sv
// Initiator for one biquad engine: accepts a sample, issues it with the y
// history and active coefficients, captures the result after ENG_LAT cycles.
module biquad_driver
  import iir_pkg::*;
#(
  parameter int    ENG_LAT       = 1,
  parameter coef_t RST_B1        = 18'sd1,
  parameter bit    CLR_ON_COMMIT = 1'b0
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  sample_t     i_audio,
  output logic        o_ready,
  input  logic        coef_we,
  input  logic [2:0]  coef_addr,
  input  coef_t       coef_wdata,
  input  logic        coef_commit,
  input  logic        i_flush,
  output logic        eng_valid,
  output sample_t     eng_audio_in,
  output sample_t     eng_y1,
  output sample_t     eng_y2,
  output coef_t       eng_b1,
  output coef_t       eng_b2,
  output coef_t       eng_b3,
  output coef_t       eng_a2,
  output coef_t       eng_a3,
  input  sample_t     eng_audio_out,
  output logic        o_valid,
  output sample_t     o_audio
);

  localparam int CW = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;

  drv_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  sample_t        x_q, x_d;
  sample_t        y1_q, y1_d;
  sample_t        y2_q, y2_d;
  sample_t        o_audio_q, o_audio_d;
  logic           flush_pend_q, flush_pend_d;
  logic           commit_applied;
  logic           wait_done;
  coef_set_t      act;

  biquad_coef_bank #(.RST_B1(RST_B1)) u_bank (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .coef_commit (coef_commit),
    .apply_ok    (state_q == ST_IDLE),
    .applied     (commit_applied),
    .active      (act)
  );

  assign wait_done = (cnt_q == CW'(ENG_LAT - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y1_d         = y1_q;
    y2_d         = y2_q;
    o_audio_d    = o_audio_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          x_d     = i_audio;
          state_d = ST_ISSUE;
        end
        if (i_flush || (CLR_ON_COMMIT && commit_applied)) begin
          y1_d = '0;
          y2_d = '0;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
        if (i_flush) flush_pend_d = 1'b1;
      end
      ST_WAIT: begin
        if (i_flush) flush_pend_d = 1'b1;
        if (wait_done) state_d = ST_CAPTURE;
        else           cnt_d   = cnt_q + CW'(1);
      end
      ST_CAPTURE: begin
        o_audio_d    = eng_audio_out;
        state_d      = ST_IDLE;
        flush_pend_d = 1'b0;
        // A flush seen during the transaction wins over the history shift.
        if (flush_pend_q || i_flush) begin
          y1_d = '0;
          y2_d = '0;
        end else begin
          y2_d = y1_q;
          y1_d = eng_audio_out;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      x_q          <= '0;
      y1_q         <= '0;
      y2_q         <= '0;
      o_audio_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
      o_audio_q    <= o_audio_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign o_ready      = (state_q == ST_IDLE);
  assign eng_valid    = (state_q == ST_ISSUE);
  assign eng_audio_in = x_q;
  assign eng_y1       = y1_q;
  assign eng_y2       = y2_q;
  assign eng_b1       = act.b1;
  assign eng_b2       = act.b2;
  assign eng_b3       = act.b3;
  assign eng_a2       = act.a2;
  assign eng_a3       = act.a3;
  assign o_valid      = (state_q == ST_CAPTURE);
  // Result is visible combinationally in CAPTURE and held from the register afterwards.
  assign o_audio      = o_valid ? eng_audio_out : o_audio_q;

endmodule
